// File: rtl/pong_pkg.sv
// Shared Pong definitions: screen geometry, FSM state encoding, direction codes.
package pong_pkg;

    localparam int SCREEN_X = 640;
    localparam int SCREEN_Y = 480;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        SCORED = 2'd2
    } state_t;

    // Horizontal and vertical directions share one encoding: 0 = towards origin.
    localparam logic LEFT  = 1'b0;
    localparam logic UP    = 1'b0;
    localparam logic RIGHT = 1'b1;
    localparam logic DOWN  = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// Step prescaler: tick is high for one clock every SPEED clocks; clear restarts the count.
module tick_gen #(
    parameter int SPEED = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(SPEED - 1);

    logic [7:0] r_timer;

    // Timer wraps at SPEED-1 and restarts from zero whenever the owner clears it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_timer <= 8'd0;
        end else if (clear || (r_timer == LAST)) begin
            r_timer <= 8'd0;
        end else begin
            r_timer <= r_timer + 8'd1;
        end
    end

    assign tick = (r_timer == LAST);

endmodule

// File: rtl/ball.sv
// Ball motion and collision stage: moves one pixel per tick, reflects off walls and
// paddles, pulses a score on a miss, and answers per-pixel draw queries.
module ball
    import pong_pkg::*;
#(
    parameter logic [2:0] COLOR      = 3'b111,
    parameter int         BALL_SIZE  = 10,
    parameter int         SPEED      = 10,
    parameter int         HOLD_TICKS = 60
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] row,
    input  logic [9:0] col,
    input  logic       serve,
    input  logic [9:0] l_pos_x,
    input  logic [9:0] l_pos_y,
    input  logic [7:0] l_size_x,
    input  logic [7:0] l_size_y,
    input  logic [9:0] r_pos_x,
    input  logic [9:0] r_pos_y,
    input  logic [7:0] r_size_x,
    input  logic [7:0] r_size_y,
    output logic [2:0] rgb,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [7:0] size_x,
    output logic [7:0] size_y,
    output logic       score_left,
    output logic       score_right,
    output logic       active
);

    localparam logic [9:0]  CENTRE_X   = 10'(SCREEN_X / 2 - BALL_SIZE / 2);
    localparam logic [9:0]  CENTRE_Y   = 10'(SCREEN_Y / 2 - BALL_SIZE / 2);
    localparam logic [10:0] SIZE_W     = 11'(BALL_SIZE);
    localparam logic [10:0] SCREEN_X_W = 11'(SCREEN_X);
    localparam logic [10:0] SCREEN_Y_W = 11'(SCREEN_Y);
    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_TICKS - 1);

    state_t     r_state, w_state_next;
    logic [9:0] r_ball_x, w_ball_x_next;
    logic [9:0] r_ball_y, w_ball_y_next;
    logic       r_dir_x, w_dir_x_next;
    logic       r_dir_y, w_dir_y_next;
    logic       r_serve_dir, w_serve_dir_next;
    logic [7:0] r_hold, w_hold_next;
    logic       r_score_left, w_score_left_next;
    logic       r_score_right, w_score_right_next;
    logic       w_tick;
    logic       w_clear;

    // Geometry is 11 bits wide so that position plus size never wraps.
    logic [10:0] w_ball_right, w_ball_bottom;
    logic [10:0] w_l_edge, w_l_bottom, w_r_bottom;
    logic        w_l_overlap, w_r_overlap;
    logic        w_l_hit, w_r_hit, w_miss_l, w_miss_r;
    logic        w_top, w_bottom;
    logic        w_dir_x_upd, w_dir_y_upd;
    logic        w_in_box;

    tick_gen #(.SPEED(SPEED)) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .clear (w_clear),
        .tick  (w_tick)
    );

    assign w_ball_right  = {1'b0, r_ball_x} + SIZE_W;
    assign w_ball_bottom = {1'b0, r_ball_y} + SIZE_W;
    assign w_l_edge      = {1'b0, l_pos_x} + {3'b000, l_size_x};
    assign w_l_bottom    = {1'b0, l_pos_y} + {3'b000, l_size_y};
    assign w_r_bottom    = {1'b0, r_pos_y} + {3'b000, r_size_y};

    assign w_l_overlap = (w_ball_bottom > {1'b0, l_pos_y}) && ({1'b0, r_ball_y} < w_l_bottom);
    assign w_r_overlap = (w_ball_bottom > {1'b0, r_pos_y}) && ({1'b0, r_ball_y} < w_r_bottom);

    assign w_l_hit  = (r_dir_x == LEFT)  && ({1'b0, r_ball_x} == w_l_edge) && w_l_overlap;
    assign w_r_hit  = (r_dir_x == RIGHT) && (w_ball_right == {1'b0, r_pos_x}) && w_r_overlap;
    assign w_miss_l = (r_dir_x == LEFT)  && (r_ball_x == 10'd0);
    assign w_miss_r = (r_dir_x == RIGHT) && (w_ball_right == SCREEN_X_W);
    assign w_top    = (r_dir_y == UP)    && (r_ball_y == 10'd0);
    assign w_bottom = (r_dir_y == DOWN)  && (w_ball_bottom == SCREEN_Y_W);

    // Wall and paddle flips are independent and may land on the same tick.
    assign w_dir_x_upd = w_l_hit ? RIGHT : (w_r_hit ? LEFT : r_dir_x);
    assign w_dir_y_upd = w_top ? DOWN : (w_bottom ? UP : r_dir_y);

    // State and datapath registers; reset recentres the ball and drops any pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_ball_x      <= CENTRE_X;
            r_ball_y      <= CENTRE_Y;
            r_dir_x       <= RIGHT;
            r_dir_y       <= DOWN;
            r_serve_dir   <= RIGHT;
            r_hold        <= 8'd0;
            r_score_left  <= 1'b0;
            r_score_right <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_ball_x      <= w_ball_x_next;
            r_ball_y      <= w_ball_y_next;
            r_dir_x       <= w_dir_x_next;
            r_dir_y       <= w_dir_y_next;
            r_serve_dir   <= w_serve_dir_next;
            r_hold        <= w_hold_next;
            r_score_left  <= w_score_left_next;
            r_score_right <= w_score_right_next;
        end
    end

    // Next-state logic: serve launch, per-tick motion and collisions, post-score hold.
    always_comb begin
        w_state_next       = r_state;
        w_ball_x_next      = r_ball_x;
        w_ball_y_next      = r_ball_y;
        w_dir_x_next       = r_dir_x;
        w_dir_y_next       = r_dir_y;
        w_serve_dir_next   = r_serve_dir;
        w_hold_next        = r_hold;
        w_score_left_next  = 1'b0;
        w_score_right_next = 1'b0;
        w_clear            = 1'b0;
        case (r_state)
            IDLE: begin
                w_ball_x_next = CENTRE_X;
                w_ball_y_next = CENTRE_Y;
                if (serve) begin
                    w_state_next = MOVING;
                    w_dir_x_next = r_serve_dir;
                    w_dir_y_next = DOWN;
                    w_clear      = 1'b1;
                end
            end
            MOVING: begin
                if (w_tick) begin
                    if (w_miss_l) begin
                        // Ball left the screen on the left: right player scores.
                        w_score_right_next = 1'b1;
                        w_serve_dir_next   = LEFT;
                        w_state_next       = SCORED;
                        w_hold_next        = 8'd0;
                        w_clear            = 1'b1;
                    end else if (w_miss_r) begin
                        w_score_left_next = 1'b1;
                        w_serve_dir_next  = RIGHT;
                        w_state_next      = SCORED;
                        w_hold_next       = 8'd0;
                        w_clear           = 1'b1;
                    end else begin
                        w_dir_x_next  = w_dir_x_upd;
                        w_dir_y_next  = w_dir_y_upd;
                        w_ball_x_next = (w_dir_x_upd == RIGHT) ? r_ball_x + 10'd1 : r_ball_x - 10'd1;
                        w_ball_y_next = (w_dir_y_upd == DOWN)  ? r_ball_y + 10'd1 : r_ball_y - 10'd1;
                    end
                end
            end
            SCORED: begin
                if (w_tick) begin
                    if (r_hold == HOLD_LAST) begin
                        w_state_next  = IDLE;
                        w_ball_x_next = CENTRE_X;
                        w_ball_y_next = CENTRE_Y;
                        w_hold_next   = 8'd0;
                    end else begin
                        w_hold_next = r_hold + 8'd1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Pixel query: the ball box is half-open on its right and bottom sides.
    assign w_in_box = ({1'b0, col} >= {1'b0, r_ball_x}) && ({1'b0, col} < w_ball_right) &&
                      ({1'b0, row} >= {1'b0, r_ball_y}) && ({1'b0, row} < w_ball_bottom);

    assign rgb         = w_in_box ? COLOR : 3'b000;
    assign pos_x       = r_ball_x;
    assign pos_y       = r_ball_y;
    assign size_x      = 8'(BALL_SIZE);
    assign size_y      = 8'(BALL_SIZE);
    assign score_left  = r_score_left;
    assign score_right = r_score_right;
    assign active      = (r_state == MOVING);

endmodule

// File: tb/tb_ball.sv
// Self-checking bench for ball: directed trajectories plus randomized games against a
// tick-level model of the bounce/score rules.
module tb_ball;

    localparam int SPEED = 2;
    localparam int HOLD  = 60;
    localparam int BS    = 10;
    localparam int SX    = 640;
    localparam int SY    = 480;
    localparam int CX    = 315;
    localparam int CY    = 235;

    logic       clock, reset, serve;
    logic [9:0] row, col, l_pos_x, l_pos_y, r_pos_x, r_pos_y;
    logic [7:0] l_size_x, l_size_y, r_size_x, r_size_y;
    logic [2:0] rgb;
    logic [9:0] pos_x, pos_y;
    logic [7:0] size_x, size_y;
    logic       score_left, score_right, active;

    int checks   = 0;
    int failures = 0;

    // Model: ball position, directions (1 = right/down) and side of next serve.
    int m_x, m_y, m_dx, m_dy, m_sdir;

    ball #(.COLOR(3'b111), .BALL_SIZE(BS), .SPEED(SPEED), .HOLD_TICKS(HOLD)) dut (
        .clock(clock), .reset(reset), .row(row), .col(col), .serve(serve),
        .l_pos_x(l_pos_x), .l_pos_y(l_pos_y), .l_size_x(l_size_x), .l_size_y(l_size_y),
        .r_pos_x(r_pos_x), .r_pos_y(r_pos_y), .r_size_x(r_size_x), .r_size_y(r_size_y),
        .rgb(rgb), .pos_x(pos_x), .pos_y(pos_y), .size_x(size_x), .size_y(size_y),
        .score_left(score_left), .score_right(score_right), .active(active)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic void model_reset();
        m_x = CX; m_y = CY; m_dx = 1; m_dy = 1; m_sdir = 1;
    endfunction

    // One step of the game rules against the paddles currently presented.
    function automatic void model_tick(output bit ml, output bit mr);
        int ndx, ndy;
        ml = (m_dx == 0) && (m_x == 0);
        mr = (m_dx == 1) && (m_x + BS == SX);
        if (ml) begin m_sdir = 0; return; end
        if (mr) begin m_sdir = 1; return; end
        ndx = m_dx; ndy = m_dy;
        if (m_dy == 0 && m_y == 0) ndy = 1;
        if (m_dy == 1 && m_y + BS == SY) ndy = 0;
        if (m_dx == 0 && m_x == int'(l_pos_x) + int'(l_size_x) &&
            m_y + BS > int'(l_pos_y) && m_y < int'(l_pos_y) + int'(l_size_y)) ndx = 1;
        if (m_dx == 1 && m_x + BS == int'(r_pos_x) &&
            m_y + BS > int'(r_pos_y) && m_y < int'(r_pos_y) + int'(r_size_y)) ndx = 0;
        m_dx = ndx; m_dy = ndy;
        m_x = m_x + ((ndx == 1) ? 1 : -1);
        m_y = m_y + ((ndy == 1) ? 1 : -1);
    endfunction

    task automatic set_paddles(input int lx, ly, lsx, lsy, rx, ry, rsx, rsy);
        l_pos_x = 10'(lx); l_pos_y = 10'(ly); l_size_x = 8'(lsx); l_size_y = 8'(lsy);
        r_pos_x = 10'(rx); r_pos_y = 10'(ry); r_size_x = 8'(rsx); r_size_y = 8'(rsy);
    endtask

    task automatic rand_paddles();
        set_paddles(int'($urandom_range(0, 30)), int'($urandom_range(0, 400)),
                    int'($urandom_range(1, 20)), int'($urandom_range(20, 200)),
                    int'($urandom_range(600, 639)), int'($urandom_range(0, 400)),
                    int'($urandom_range(1, 20)), int'($urandom_range(20, 200)));
    endtask

    // Advance one step tick; compare position, score pulses, active and a pixel query.
    task automatic play_tick(output bit ml, output bit mr);
        int off_c, off_r;
        bit exp_in;
        model_tick(ml, mr);
        repeat (SPEED) @(posedge clock);
        #1;
        checks++;
        if ({pos_x, pos_y} !== {10'(m_x), 10'(m_y)}) begin
            failures++;
            $display("FAIL tick_pos: got (%0d,%0d) expected (%0d,%0d)", pos_x, pos_y, m_x, m_y);
        end
        checks++;
        if ({score_left, score_right} !== {mr, ml}) begin
            failures++;
            $display("FAIL tick_score: got L=%0b R=%0b expected L=%0b R=%0b", score_left, score_right, mr, ml);
        end
        checks++;
        if (active !== !(ml || mr)) begin
            failures++;
            $display("FAIL tick_active: got %0b expected %0b", active, !(ml || mr));
        end
        off_c = int'($urandom_range(0, 13)) - 2;
        off_r = int'($urandom_range(0, 13)) - 2;
        col   = 10'(m_x + off_c);
        row   = 10'(m_y + off_r);
        serve = 1'($urandom_range(0, 1));
        #1;
        exp_in = (int'(col) >= m_x) && (int'(col) < m_x + BS) && (int'(row) >= m_y) && (int'(row) < m_y + BS);
        checks++;
        if (rgb !== (exp_in ? 3'b111 : 3'b000)) begin
            failures++;
            $display("FAIL rgb: row=%0d col=%0d got %0d expected %0d", row, col, rgb, exp_in ? 7 : 0);
        end
    endtask

    task automatic serve_ball();
        @(negedge clock);
        serve = 1'b1;
        @(posedge clock);
        #1;
        serve = 1'b0;
        m_x = CX; m_y = CY; m_dx = m_sdir; m_dy = 1;
        checks++;
        if ({active, score_left, score_right, pos_x, pos_y} !== {3'b100, 10'd315, 10'd235}) begin
            failures++;
            $display("FAIL serve_launch: got active=%0b pos=(%0d,%0d) expected active=1 pos=(315,235)", active, pos_x, pos_y);
        end
    endtask

    task automatic run_until(input int tx, ty, tdx, tdy, budget);
        bit ml, mr, found;
        found = 0;
        for (int i = 0; i < budget; i++) begin
            if (m_x == tx && m_y == ty && m_dx == tdx && m_dy == tdy) begin found = 1; break; end
            play_tick(ml, mr);
            if (ml || mr) break;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL reach_target: got (%0d,%0d) expected (%0d,%0d)", m_x, m_y, tx, ty);
        end
    endtask

    task automatic run_to_miss(input int budget, input bit rerand, output bit ml, output bit mr);
        ml = 0; mr = 0;
        for (int i = 0; i < budget; i++) begin
            if (rerand && (i % 100 == 99)) rand_paddles();
            play_tick(ml, mr);
            if (ml || mr) break;
        end
    endtask

    // Called at one clock past the miss: pulse width, frozen ball, timed recentre, serve ignored.
    task automatic hold_phase();
        int fx, fy;
        fx = m_x; fy = m_y;
        @(posedge clock);
        #1;
        checks++;
        if ({score_left, score_right} !== 2'b00) begin
            failures++;
            $display("FAIL pulse_width: got L=%0b R=%0b expected 0 0", score_left, score_right);
        end
        serve = 1'b1;
        repeat (SPEED * HOLD - 2) @(posedge clock);
        #1;
        checks++;
        if ({pos_x, pos_y, active} !== {10'(fx), 10'(fy), 1'b0}) begin
            failures++;
            $display("FAIL hold_frozen: got (%0d,%0d) active=%0b expected (%0d,%0d) active=0", pos_x, pos_y, active, fx, fy);
        end
        serve = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if ({pos_x, pos_y, active} !== {10'd315, 10'd235, 1'b0}) begin
            failures++;
            $display("FAIL hold_end: got (%0d,%0d) active=%0b expected (315,235) active=0", pos_x, pos_y, active);
        end
        m_x = CX; m_y = CY;
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if ({pos_x, pos_y, active} !== {10'd315, 10'd235, 1'b0}) begin
            failures++;
            $display("FAIL idle_wait: got (%0d,%0d) active=%0b expected (315,235) active=0", pos_x, pos_y, active);
        end
    endtask

    task automatic async_reset_check(input string name);
        serve = 1'b0;
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({pos_x, pos_y, active, score_left, score_right} !== {10'd315, 10'd235, 3'b000}) begin
            failures++;
            $display("FAIL %s: got (%0d,%0d) active=%0b L=%0b R=%0b expected (315,235) 0 0 0",
                     name, pos_x, pos_y, active, score_left, score_right);
        end
        model_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; serve = 1'b0; row = 10'd235; col = 10'd315;
        set_paddles(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({pos_x, pos_y, active, score_left, score_right} !== {10'd315, 10'd235, 3'b000}) begin
            failures++;
            $display("FAIL reset_state: got (%0d,%0d) active=%0b L=%0b R=%0b", pos_x, pos_y, active, score_left, score_right);
        end
        checks++;
        if ({size_x, size_y} !== {8'd10, 8'd10}) begin
            failures++;
            $display("FAIL size: got %0d x %0d expected 10 x 10", size_x, size_y);
        end
        checks++;
        if (rgb !== 3'b111) begin failures++; $display("FAIL rgb_corner: got %0d expected 7", rgb); end
        col = 10'd325; #1;
        checks++;
        if (rgb !== 3'b000) begin failures++; $display("FAIL rgb_right_edge: got %0d expected 0", rgb); end
        col = 10'd324; row = 10'd244; #1;
        checks++;
        if (rgb !== 3'b111) begin failures++; $display("FAIL rgb_far_corner: got %0d expected 7", rgb); end
        row = 10'd234; #1;
        checks++;
        if (rgb !== 3'b000) begin failures++; $display("FAIL rgb_above: got %0d expected 0", rgb); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Serve, then steer off the right paddle into a top-wall/left-paddle corner double flip.
    task automatic test_serve_and_corner();
        bit ml, mr;
        set_paddles(190, 0, 10, 50, 620, 380, 10, 100);
        serve_ball();
        play_tick(ml, mr);
        play_tick(ml, mr);
        checks++;
        if ({pos_x, pos_y} !== {10'd317, 10'd237}) begin
            failures++;
            $display("FAIL serve_two_ticks: got (%0d,%0d) expected (317,237)", pos_x, pos_y);
        end
        run_until(200, 0, 0, 0, 800);
        play_tick(ml, mr);
        checks++;
        if ({pos_x, pos_y} !== {10'd201, 10'd1}) begin
            failures++;
            $display("FAIL corner_flip: got (%0d,%0d) expected (201,1)", pos_x, pos_y);
        end
        play_tick(ml, mr);
        set_paddles(0, 0, 0, 0, 0, 0, 0, 0);
        run_to_miss(1000, 1'b0, ml, mr);
        checks++;
        if (!mr) begin failures++; $display("FAIL right_miss: got L=%0b R=%0b expected right-side miss", ml, mr); end
        hold_phase();
    endtask

    task automatic test_left_hit();
        bit ml, mr;
        set_paddles(5, 190, 10, 100, 620, 380, 10, 100);
        serve_ball();
        run_until(15, 185, 0, 1, 1000);
        play_tick(ml, mr);
        checks++;
        if ({pos_x, pos_y} !== {10'd16, 10'd186}) begin
            failures++;
            $display("FAIL left_paddle_hit: got (%0d,%0d) expected (16,186)", pos_x, pos_y);
        end
        set_paddles(0, 0, 0, 0, 0, 0, 0, 0);
        run_to_miss(1000, 1'b0, ml, mr);
        checks++;
        if (!mr) begin failures++; $display("FAIL exit_right: got L=%0b R=%0b expected right-side miss", ml, mr); end
        hold_phase();
    endtask

    task automatic test_left_miss();
        bit ml, mr;
        set_paddles(5, 300, 10, 100, 620, 380, 10, 100);
        serve_ball();
        run_to_miss(1200, 1'b0, ml, mr);
        checks++;
        if (!(ml && m_y == 200)) begin
            failures++;
            $display("FAIL left_miss: got miss_left=%0b y=%0d expected 1 y=200", ml, m_y);
        end
        hold_phase();
        serve_ball();
        play_tick(ml, mr);
        checks++;
        if ({pos_x, pos_y} !== {10'd314, 10'd236}) begin
            failures++;
            $display("FAIL serve_left: got (%0d,%0d) expected (314,236)", pos_x, pos_y);
        end
    endtask

    task automatic test_reset_mid_flight_and_hold();
        bit ml, mr;
        for (int i = 0; i < 5; i++) play_tick(ml, mr);
        async_reset_check("reset_mid_flight");
        set_paddles(0, 0, 0, 0, 0, 0, 0, 0);
        serve_ball();
        play_tick(ml, mr);
        checks++;
        if ({pos_x, pos_y} !== {10'd316, 10'd236}) begin
            failures++;
            $display("FAIL serve_after_reset: got (%0d,%0d) expected (316,236)", pos_x, pos_y);
        end
        run_to_miss(500, 1'b0, ml, mr);
        repeat (30) @(posedge clock);
        async_reset_check("reset_mid_hold");
    endtask

    task automatic test_random_games();
        bit ml, mr;
        for (int g = 0; g < 6; g++) begin
            rand_paddles();
            repeat ($urandom_range(0, 7)) @(posedge clock);
            serve_ball();
            run_to_miss(700, 1'b1, ml, mr);
            if (ml || mr) hold_phase();
            else async_reset_check("reset_random_game");
        end
    endtask

    initial begin
        test_reset();
        test_serve_and_corner();
        test_left_hit();
        test_left_miss();
        test_reset_mid_flight_and_hold();
        test_random_games();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ball.md
Name: ball

Overview:
Ball motion and collision stage of the Pong GUI. It consumes the position and size outputs of both paddle instances and moves the ball one pixel per step tick. It reflects the ball off the top/bottom walls and off the paddles, and emits a one-cycle score pulse when a side misses. It also answers per-pixel draw queries from the VGA scan, exactly as the paddle does.

Parameters:
COLOR, 3'b111, rgb driven inside the ball box
SCREEN_X, 640, screen width in pixels
SCREEN_Y, 480, screen height in pixels
BALL_SIZE, 10, ball side length in pixels (square)
SPEED, 10, clocks per step tick; range 1..255
HOLD_TICKS, 60, step ticks spent in SCORED before returning to IDLE

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low; low forces the reset state immediately
row  in  10  pixel row being drawn
col  in  10  pixel column being drawn
serve  in  1  level; launches the ball when sampled high in IDLE
l_pos_x, l_pos_y  in  10 each  left paddle top-left corner
l_size_x, l_size_y  in  8 each  left paddle size
r_pos_x, r_pos_y  in  10 each  right paddle top-left corner
r_size_x, r_size_y  in  8 each  right paddle size
rgb  out  3  COLOR when (row,col) is inside the ball box, else 3'b000
pos_x, pos_y  out  10 each  ball top-left corner
size_x, size_y  out  8 each  constant BALL_SIZE
score_left  out  1  one-cycle pulse: left player scored (ball reached the right edge)
score_right  out  1  one-cycle pulse: right player scored (ball reached the left edge)
active  out  1  high while in MOVING

Behaviour:
- Reset values (async on reset low):
  - state=IDLE, timer=0, hold=0
  - pos_x=SCREEN_X/2-BALL_SIZE/2 (315), pos_y=SCREEN_Y/2-BALL_SIZE/2 (235)
  - dir_x=RIGHT, dir_y=DOWN, serve_dir=RIGHT
  - score_left=score_right=0, active=0
- Step tick: timer counts 0..SPEED-1 and asserts tick for one clock when timer==SPEED-1. timer clears on entry to MOVING and on entry to SCORED.
- IDLE:
  - Ball held at centre.
  - If serve=1: next clock state=MOVING, dir_x=serve_dir, dir_y=DOWN, active=1.
  - serve is ignored in every other state.
- MOVING: on each tick evaluate the rules below against the current pos; all arithmetic is 11-bit, so pos+size never wraps.
  - Top wall: dir_y=UP and pos_y==0 -> dir_y=DOWN.
  - Bottom wall: dir_y=DOWN and pos_y+BALL_SIZE==SCREEN_Y -> dir_y=UP.
  - Left paddle hit: dir_x=LEFT, pos_x==l_pos_x+l_size_x, pos_y+BALL_SIZE>l_pos_y and pos_y<l_pos_y+l_size_y -> dir_x=RIGHT.
  - Right paddle hit: dir_x=RIGHT, pos_x+BALL_SIZE==r_pos_x, and the same vertical overlap test against the right paddle -> dir_x=LEFT.
  - Left miss: dir_x=LEFT and pos_x==0 -> score_right=1 for one clock, serve_dir=LEFT, state=SCORED, no move.
  - Right miss: dir_x=RIGHT and pos_x+BALL_SIZE==SCREEN_X -> score_left=1 for one clock, serve_dir=RIGHT, state=SCORED, no move.
  - Otherwise pos moves ±1 in x and y using the updated directions, in the same tick.
  - Wall and paddle flips on the same tick both apply. A miss overrides a wall flip.
- SCORED:
  - Ball frozen, active=0.
  - hold counts ticks; at hold==HOLD_TICKS-1 -> state=IDLE, pos recentred, hold=0.
- rgb is combinational from row, col, pos_x, pos_y (box test: col in [pos_x, pos_x+BALL_SIZE), row in [pos_y, pos_y+BALL_SIZE)).
- Paddle inputs are sampled only on tick; they may change on any clock.
- Reset asserted mid-flight or mid-hold aborts immediately to the reset state. No pulse is emitted.

Decomposition:
- Shared package pong_pkg holds:
  - SCREEN_X, SCREEN_Y
  - state encoding IDLE=2'd0, MOVING=2'd1, SCORED=2'd2
  - direction constants LEFT/UP=1'b0, RIGHT/DOWN=1'b1
- Sub-module tick_gen (parameter SPEED; ports clock, reset, clear, tick) implements the step prescaler. The paddle adopts the same sub-module for its motion timer.

Test Plan:
- Reset, then serve=1 with SPEED=2 -> after 1 clock active=1; after 2 ticks pos=(317,237).
- Start at (300,1) moving RIGHT/UP -> after 1 tick pos=(301,0); next tick dir_y=DOWN, pos=(302,1).
- Left paddle at x=5 (size 10x100), y=190; ball at (15,200) moving LEFT -> next tick dir_x=RIGHT, pos_x=16.
- Same setup but paddle y=300 -> ball passes; at pos_x==0, score_right=1 for exactly one clock, state=SCORED. After 60 ticks pos=(315,235), IDLE. Next serve launches LEFT.
- Corner case: ball at (15,0) moving LEFT/UP with the paddle overlapping -> both directions flip on one tick, pos=(16,1).
- Assert reset low during SCORED hold -> pos=(315,235), state IDLE, score pulses 0, asynchronously before the next clock edge.
